// File: rtl/collatz_pkg.sv
// Shared types and result codes for the Collatz iteration engine.
package collatz_pkg;

  // Engine control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result codes reported on err.
  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_ZERO  = 2'd1;
  localparam logic [1:0] ERR_OVF   = 2'd2;
  localparam logic [1:0] ERR_LIMIT = 2'd3;

endpackage

// File: rtl/collatz_step.sv
// One combinational Collatz step: n/2 for even n, 3n+1 for odd n.
// The odd branch is formed two bits wider than n so that any carry out
// of the WIDTH-bit range is visible as an overflow instead of wrapping.
module collatz_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] next,
  output logic             ovf,
  output logic             is_one
);

  logic [WIDTH+1:0] tripled;

  // Select the successor of n and flag a 3n+1 result that no longer fits.
  always_comb begin
    tripled = {1'b0, n, 1'b0} + {2'b00, n} + {{(WIDTH+1){1'b0}}, 1'b1};
    next    = {1'b0, n[WIDTH-1:1]};
    ovf     = 1'b0;
    if (n[0]) begin
      next = tripled[WIDTH-1:0];
      ovf  = |tripled[WIDTH+1:WIDTH];
    end
    is_one = (next == {{(WIDTH-1){1'b0}}, 1'b1});
  end

endmodule

// File: rtl/collatz_engine.sv
// Collatz iteration engine: loads a start value, applies one step per clock,
// counts steps until n reaches 1 and tracks the largest value seen.
// Runs end on reaching 1, on a 3n+1 overflow or on hitting the step limit;
// an abort drops back to IDLE silently with partial results left in place.
module collatz_engine
  import collatz_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8,
  parameter int MAX_STEPS = 2**CNT_WIDTH - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     n_in,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] steps,
  output logic [WIDTH-1:0]     peak,
  output logic [1:0]           err
);

  // Step count that ends a run which has not yet reached 1.
  localparam logic [CNT_WIDTH:0] STEP_LIMIT = (CNT_WIDTH+1)'(MAX_STEPS);

  localparam logic [WIDTH-1:0] N_ZERO = '0;
  localparam logic [WIDTH-1:0] N_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t             state;
  logic [WIDTH-1:0]   n_q;
  logic [WIDTH-1:0]   step_next;
  logic               step_ovf;
  logic               step_is_one;
  logic [CNT_WIDTH:0] steps_inc;

  collatz_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .n      (n_q),
    .next   (step_next),
    .ovf    (step_ovf),
    .is_one (step_is_one)
  );

  // Incremented count, one bit wider so the limit compare cannot wrap.
  always_comb begin
    steps_inc = {1'b0, steps} + {{CNT_WIDTH{1'b0}}, 1'b1};
  end

  // Control FSM with registered busy/done and the per-run result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n_q   <= '0;
      steps <= '0;
      peak  <= '0;
      err   <= ERR_OK;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            n_q   <= n_in;
            peak  <= n_in;
            steps <= '0;
            err   <= ERR_OK;
            if (n_in == N_ZERO) begin
              err   <= ERR_ZERO;
              state <= DONE;
              done  <= 1'b1;
            end else if (n_in == N_ONE) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end

        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (step_ovf) begin
            err   <= ERR_OVF;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            n_q   <= step_next;
            steps <= steps_inc[CNT_WIDTH-1:0];
            if (step_next > peak) begin
              peak <= step_next;
            end
            if (step_is_one) begin
              err   <= ERR_OK;
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (steps_inc == STEP_LIMIT) begin
              err   <= ERR_LIMIT;
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/collatz_engine.md
Name: collatz_engine

Overview:
Parametrised Collatz iteration engine. Loads a WIDTH-bit start value and applies one Collatz step per clock: n/2 if even, 3n+1 if odd. It counts steps until n reaches 1 and tracks the peak value. Successor to the 8-bit single-mode Collatz counter: adds a start/done handshake, abort, overflow detection, step limit and error codes. Sits behind the top-level I/O wrapper, which maps its ports onto ui/uo/uio pins.

Parameters:
WIDTH, 16, bit width of n_in, the internal n register and peak.
CNT_WIDTH, 8, bit width of the step counter.
MAX_STEPS, 2**CNT_WIDTH-1, step limit; reaching it without n==1 ends the run with ERR_LIMIT.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  request to begin; accepted only in IDLE
n_in  in  WIDTH  start value, sampled on the accepting edge
abort  in  1  cancel the current run; honoured only in RUN
busy  out  1  high while in RUN
done  out  1  one-cycle pulse when a run completes; error runs included, aborted runs excluded
steps  out  CNT_WIDTH  steps taken by the last completed or in-progress run
peak  out  WIDTH  largest n value seen in the run, start value included
err  out  2  result code of the last completed run

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE; busy=0, done=0, steps=0, peak=0, err=ERR_OK, internal n=0. Reset overrides start and abort, and aborts a run in progress.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - n<=n_in, peak<=n_in, steps<=0, err<=ERR_OK.
  - n_in==0: go to DONE with err=ERR_ZERO.
  - n_in==1: go to DONE with steps=0.
  - Otherwise go to RUN.
  - start=0 keeps IDLE; outputs hold the previous run's results.
- RUN, one step per clk edge:
  - next = n even ? n>>1 : 3n+1.
  - 3n+1 is computed at WIDTH+2 bits.
  - If the high 2 bits are nonzero: overflow. n and peak are not updated, steps is not incremented, err=ERR_OVF, go to DONE.
  - Otherwise: n<=next, steps<=steps+1, peak<=max(peak,next).
  - next==1: go to DONE, err=ERR_OK.
  - Else if steps+1==MAX_STEPS: go to DONE, err=ERR_LIMIT.
  - Both conditions true on the same edge: ERR_OK wins.
  - abort=1: go to IDLE with no done pulse and no step applied that edge. steps and peak hold partial values; err holds ERR_OK.
  - start in RUN is ignored.
- DONE: lasts exactly one cycle with done=1, busy=0, then goes unconditionally to IDLE. start during DONE is ignored and must be re-asserted in IDLE.
- busy is a registered decode of the state (high in RUN only). done is high in DONE only.
- Latency: a run of k steps goes start edge → RUN for k cycles → DONE. done is seen k+1 cycles after the accepting edge. n_in 0 or 1: done the cycle after the accepting edge.
- Results (steps, peak, err) stay stable from the done pulse until the next accepted start or reset.

Decomposition:
- Package collatz_pkg holds:
  - state_t enum {IDLE, RUN, DONE};
  - err codes ERR_OK=2'd0, ERR_ZERO=2'd1, ERR_OVF=2'd2, ERR_LIMIT=2'd3.
- Sub-module collatz_step, combinational, parametrised by WIDTH:
  - input n;
  - outputs next[WIDTH-1:0], ovf, is_one (next==1).
- collatz_engine holds the FSM, registers and counters, and instantiates collatz_step.

Test Plan:
- Defaults, n_in=6, start pulse → busy high 8 cycles, done pulse; steps=8, peak=16, err=0 (sequence 6,3,10,5,16,8,4,2,1).
- Defaults, n_in=27 → steps=111, peak=9232, err=0. Then n_in=1 → done next cycle, steps=0, peak=1, err=0.
- n_in=0 → done next cycle, err=1, steps=0.
- WIDTH=8: n_in=7 → steps=16, peak=52, err=0. n_in=27 → err=2, peak ≤255, done asserted.
- CNT_WIDTH=4 (MAX_STEPS=15), n_in=27 → done after 15 steps, steps=15, err=3.
- Abort and reset: n_in=27, abort on RUN cycle 5 → IDLE, no done, steps=5. Restart with rst asserted mid-run → all outputs zero next cycle, no done. start held during RUN/DONE is ignored.
